seq_pattern_tx: RTL

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: shifts up to eight pattern bits MSB-first onto x_out
// and keeps a modulo-4 running count of the 1-bits it has emitted.
module seq_pattern_tx #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [3:0] len,
    input  logic       clr_cnt,
    output logic       x_out,
    output logic       busy,
    output logic       done,
    output logic       ready,
    output logic [1:0] ones_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] shreg_r, shreg_s;
    logic [2:0] rem_r, rem_s;
    logic       x_r, x_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic [1:0] cnt_r, cnt_s;
    logic       emit_one_s;
    logic [3:0] len_m1_s;

    // Lengths beyond the register width saturate to a full byte.
    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l > 4'd8) begin
            clamp_len = 4'd8;
        end else begin
            clamp_len = l;
        end
    endfunction

    // Next-state, next-output and ones-counter logic.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        rem_s      = rem_r;
        x_s        = x_r;
        busy_s     = busy_r;
        done_s     = done_r;
        emit_one_s = 1'b0;
        len_m1_s   = clamp_len(len) - 4'd1;
        case (state_r)
            IDLE: begin
                if (start && (len != 4'd0)) begin
                    x_s        = data_in[7];
                    busy_s     = 1'b1;
                    shreg_s    = {data_in[6:0], 1'b0};
                    rem_s      = len_m1_s[2:0];
                    emit_one_s = data_in[7];
                    state_s    = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_r != 3'd0) begin
                    x_s        = shreg_r[7];
                    shreg_s    = {shreg_r[6:0], 1'b0};
                    rem_s      = rem_r - 3'd1;
                    emit_one_s = shreg_r[7];
                end else begin
                    x_s     = IDLE_LEVEL;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = DONE;
                end
            end
            DONE: begin
                done_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                x_s     = IDLE_LEVEL;
                busy_s  = 1'b0;
                done_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
        // A clear wins over an increment landing on the same edge.
        if (clr_cnt) begin
            cnt_s = 2'd0;
        end else if (emit_one_s) begin
            cnt_s = cnt_r + 2'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            shreg_r <= 8'd0;
            rem_r   <= 3'd0;
            x_r     <= IDLE_LEVEL;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            rem_r   <= rem_s;
            x_r     <= x_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            cnt_r   <= cnt_s;
        end
    end

    assign x_out    = x_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign ones_cnt = cnt_r;
    assign ready    = (state_r == IDLE);

endmodule
